// File: rtl/dbus_pair_responder.sv
`default_nettype none
// ============================================================================
// dbus_pair_responder: serializes two issue-lane data-bus requests onto one
// downstream port (lane 1 first) and returns per-lane responses plus d_wait.
// Optional build macro: DBUS_PAIR_FWD_EN (in-batch lane1 store -> lane0 load).
// Revision: 1.0
// ============================================================================
module dbus_pair_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [5:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic [1:0]  dresp_addr_ok,
    output logic [1:0]  dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        d_wait,
    output logic        oreq_valid,
    output logic [31:0] oreq_addr,
    output logic [2:0]  oreq_size,
    output logic [3:0]  oreq_strobe,
    output logic [31:0] oreq_data,
    input  logic        oresp_addr_ok,
    input  logic        oresp_data_ok,
    input  logic [31:0] oresp_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
`ifdef DBUS_PAIR_FWD_EN
    localparam logic [1:0] FWD  = 2'd3;
`endif

    logic [1:0]  state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic        cur_q, cur_d;
    logic        done;
    logic [31:0] done_data;

`ifdef DBUS_PAIR_FWD_EN
    logic        fwd_q, fwd_d;
    logic [31:0] fwd_data_q, fwd_data_d;
    logic        fwd_hit;

    // Lane 0 may only reuse lane 1 store data when the whole word is written.
    assign fwd_hit = (dreq_valid == 2'b11) && (dreq_strobe[7:4] == 4'hF) &&
                     (dreq_strobe[3:0] == 4'h0) && (dreq_addr[63:34] == dreq_addr[31:2]);
`endif

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cur_d     = cur_q;
        done      = 1'b0;
        done_data = oresp_data;
        d_wait    = 1'b0;
`ifdef DBUS_PAIR_FWD_EN
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
`endif
        case (state_q)
            IDLE: begin
                d_wait = |dreq_valid;
                if (|dreq_valid) begin
                    pend_d  = dreq_valid;
                    cur_d   = dreq_valid[1];
                    state_d = ADDR;
`ifdef DBUS_PAIR_FWD_EN
                    fwd_d      = fwd_hit;
                    fwd_data_d = dreq_data[63:32];
`endif
                end
            end
            ADDR: begin
                d_wait = 1'b1;
                if (oresp_addr_ok) begin
                    if (oresp_data_ok) begin
                        done = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                d_wait = 1'b1;
                if (oresp_data_ok) begin
                    done = 1'b1;
                end
            end
`ifdef DBUS_PAIR_FWD_EN
            FWD: begin
                done      = 1'b1;
                done_data = fwd_data_q;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // d_wait drops only in the cycle that finishes the last pending lane.
        if (done) begin
            pend_d[cur_q] = 1'b0;
            if (cur_q && pend_q[0]) begin
                cur_d   = 1'b0;
                d_wait  = 1'b1;
`ifdef DBUS_PAIR_FWD_EN
                state_d = fwd_q ? FWD : ADDR;
`else
                state_d = ADDR;
`endif
            end else begin
                state_d = IDLE;
                d_wait  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            cur_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
        end
    end

`ifdef DBUS_PAIR_FWD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= 32'd0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`endif

    always_comb begin
        oreq_valid  = (state_q == ADDR);
        oreq_addr   = 32'd0;
        oreq_size   = 3'd0;
        oreq_strobe = 4'd0;
        oreq_data   = 32'd0;
        if (state_q == ADDR) begin
            oreq_addr   = cur_q ? dreq_addr[63:32]   : dreq_addr[31:0];
            oreq_size   = cur_q ? dreq_size[5:3]     : dreq_size[2:0];
            oreq_strobe = cur_q ? dreq_strobe[7:4]   : dreq_strobe[3:0];
            oreq_data   = cur_q ? dreq_data[63:32]   : dreq_data[31:0];
        end
    end

    always_comb begin
        dresp_addr_ok = 2'b00;
        dresp_data_ok = 2'b00;
        dresp_data    = 64'd0;
        if (done) begin
            dresp_addr_ok = cur_q ? 2'b10 : 2'b01;
            dresp_data_ok = cur_q ? 2'b10 : 2'b01;
            dresp_data    = cur_q ? {done_data, 32'd0} : {32'd0, done_data};
        end
    end

endmodule
`default_nettype wire
